// File: rtl/rtp_result_collector.sv
// Result collector and performance monitor for the ray-traversal core: round-robin gathers
// per-channel hit results into a first-word-fall-through FIFO and tracks run statistics.
module rtp_result_collector #(
    parameter int          NUM_CH     = 2,
    parameter int          ID_W       = 32,
    parameter int          T_W        = 32,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CNT_W      = 64,
    parameter int unsigned TIMEOUT    = 1000000,
    parameter logic [T_W-1:0] MISS_VALUE = T_W'(32'h7F7FFFFF),
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_CH-1:0]      ch_valid,
    output logic [NUM_CH-1:0]      ch_ready,
    input  logic [NUM_CH*ID_W-1:0] ch_ray_id,
    input  logic [NUM_CH*T_W-1:0]  ch_hitT,
    input  logic [NUM_CH-1:0]      ch_finish,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_ray_id,
    output logic [T_W-1:0]         out_hitT,
    output logic [CH_W-1:0]        out_ch,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [31:0]            result_count,
    output logic [31:0]            miss_count,
    output logic [1:0]             dbg_state
);

    // Handshake: a channel result transfers on a cycle where ch_valid[i] && ch_ready[i];
    // the FIFO head transfers on a cycle where out_valid && out_ready. Valid never waits on ready.

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_q;
    logic [NUM_CH-1:0] fin_q;
    logic [CNT_W-1:0]  cyc_q;
    logic [31:0]       res_q, miss_q, wd_q;
    logic              timeout_q;

    logic [ID_W-1:0]   id_mem [FIFO_DEPTH];
    logic [T_W-1:0]    t_mem  [FIFO_DEPTH];
    logic [CH_W-1:0]   ch_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q;

    logic              fifo_full, fifo_empty, arb_en, enter_run;
    logic              grant_found, accept, pop, is_miss, wd_expire;
    logic [CH_W-1:0]   grant_idx, cand;
    logic [ID_W-1:0]   g_id;
    logic [T_W-1:0]    g_hitT;

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] p, input int o);
        int c;
        c = int'(p) + o;
        if (c >= NUM_CH) c -= NUM_CH;
        return CH_W'(c);
    endfunction

    assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign arb_en     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign enter_run  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign pop        = !fifo_empty && out_ready;

    // Circular search for the first valid channel starting at the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int o = 0; o < NUM_CH; o++) begin
            cand = wrap_add(rr_q, o);
            if (!grant_found && ch_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept   = arb_en && grant_found && !fifo_full;
    assign ch_ready = accept ? (NUM_CH'(1) << grant_idx) : '0;
    assign g_id     = ch_ray_id[grant_idx*ID_W +: ID_W];
    assign g_hitT   = ch_hitT[grant_idx*T_W +: T_W];
    assign is_miss  = (g_hitT == MISS_VALUE);
    assign wd_expire = (TIMEOUT != 0) && !accept && (wd_q == TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (&(fin_q | ch_finish)) state_d = S_DRAIN;
                else if (wd_expire)       state_d = S_DONE;
            end
            S_DRAIN: if (fifo_empty && !(|ch_valid)) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            fin_q     <= '0;
            cyc_q     <= '0;
            res_q     <= '0;
            miss_q    <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) rr_q <= wrap_add(grant_idx, 1);
            if (enter_run) begin
                fin_q     <= '0;
                cyc_q     <= '0;
                res_q     <= '0;
                miss_q    <= '0;
                wd_q      <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (arb_en && (cyc_q != '1)) cyc_q <= cyc_q + 1'b1;
                if (state_q == S_RUN) fin_q <= fin_q | ch_finish;
                if (accept && (res_q != '1)) res_q <= res_q + 1'b1;
                if (accept && is_miss && (miss_q != '1)) miss_q <= miss_q + 1'b1;
                if ((state_q == S_RUN) && (TIMEOUT != 0)) wd_q <= accept ? '0 : wd_q + 1'b1;
                if ((state_q == S_RUN) && (state_d == S_DONE)) timeout_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || enter_run) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (accept) wr_q <= wr_q + 1'b1;
            if (pop)    rd_q <= rd_q + 1'b1;
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates everything that reads it.
    always_ff @(posedge clock) begin
        if (accept) begin
            id_mem[wr_q] <= g_id;
            t_mem[wr_q]  <= g_hitT;
            ch_mem[wr_q] <= grant_idx;
        end
    end

    assign out_valid    = !fifo_empty;
    assign out_ray_id   = fifo_empty ? '0 : id_mem[rd_q];
    assign out_hitT     = fifo_empty ? '0 : t_mem[rd_q];
    assign out_ch       = fifo_empty ? '0 : ch_mem[rd_q];
    assign busy         = arb_en;
    assign done         = (state_q == S_DONE);
    assign timeout      = timeout_q;
    assign cycle_count  = cyc_q;
    assign result_count = res_q;
    assign miss_count   = miss_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rtp_result_collector.sv
// Directed bench for rtp_result_collector: reset, streaming, round-robin, backpressure,
// drain, watchdog and mid-run reset, checked with immediate assertions.
module tb_rtp_result_collector;

    logic        clock, reset, start, out_ready;
    logic [1:0]  ch_valid, ch_ready, ch_finish;
    logic [63:0] ch_ray_id, ch_hitT;
    logic        out_valid, busy, done, timeout;
    logic [31:0] out_ray_id, out_hitT, result_count, miss_count;
    logic [0:0]  out_ch;
    logic [63:0] cycle_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] hits [3];

    rtp_result_collector #(
        .NUM_CH(2), .ID_W(32), .T_W(32), .FIFO_DEPTH(16), .CNT_W(64), .TIMEOUT(100)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_ray_id(ch_ray_id), .ch_hitT(ch_hitT),
        .ch_finish(ch_finish), .out_valid(out_valid), .out_ready(out_ready),
        .out_ray_id(out_ray_id), .out_hitT(out_hitT), .out_ch(out_ch),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count),
        .result_count(result_count), .miss_count(miss_count), .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL sim_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic finish_run();
        ch_finish = 2'b11;
        cyc();
        ch_finish = 2'b00;
        cyc();
        cyc();
        chk("finish_done", done, 1);
        chk("finish_busy", busy, 0);
    endtask

    initial begin
        hits[0] = 32'h3F800000;
        hits[1] = 32'h7F7FFFFF;
        hits[2] = 32'h40000000;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        ch_valid = '0; ch_finish = '0; ch_ray_id = '0; ch_hitT = '0;

        // Reset
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_ready", ch_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_results", result_count, 0);
        chk("rst_misses", miss_count, 0);
        chk("rst_state", dbg_state, 0);

        // Round-robin with both channels continuously valid
        start_run();
        chk("rr_busy", busy, 1);
        out_ready = 1'b1;
        ch_valid = 2'b11;
        ch_ray_id = {32'hB0, 32'hA0};
        ch_hitT = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready", ch_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            cyc();
            #1;
            chk("rr_out_ch", out_ch, (k % 2 == 0) ? 0 : 1);
            chk("rr_out_id", out_ray_id, (k % 2 == 0) ? 32'hA0 : 32'hB0);
        end
        ch_valid = 2'b00;
        #1;
        chk("rr_results", result_count, 6);
        chk("rr_misses", miss_count, 0);
        finish_run();

        // Single stream on channel 0
        start_run();
        chk("ss_counts_cleared", result_count, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch_valid = 2'b01;
            ch_ray_id = {32'h0, 32'(i)};
            ch_hitT = {32'h0, hits[i]};
            #1;
            chk("ss_ready", ch_ready, 2'b01);
            cyc();
            ch_valid = 2'b00;
            #1;
            chk("ss_out_valid", out_valid, 1);
            chk("ss_out_id", out_ray_id, i);
            chk("ss_out_hitT", out_hitT, hits[i]);
            chk("ss_out_ch", out_ch, 0);
        end
        chk("ss_results", result_count, 3);
        chk("ss_misses", miss_count, 1);
        chk("ss_cycles", cycle_count, 3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("ss_start_ignored_results", result_count, 3);
        chk("ss_start_ignored_cycles", cycle_count, 4);
        chk("ss_popped", out_valid, 0);
        finish_run();

        // Backpressure, full FIFO, wrap-around ordering
        start_run();
        out_ready = 1'b0;
        ch_valid = 2'b01;
        ch_hitT = '0;
        for (int i = 0; i < 16; i++) begin
            ch_ray_id = {32'h0, 32'(i)};
            #1;
            chk("bp_ready", ch_ready, 2'b01);
            exp_q.push_back(32'(i));
            cyc();
        end
        ch_ray_id = {32'h0, 32'd16};
        #1;
        chk("bp_full_ready", ch_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_full_pop_ready", ch_ready, 0);
        chk("bp_head", out_ray_id, exp_q.pop_front());
        cyc();
        out_ready = 1'b0;
        #1;
        chk("bp_one_more_ready", ch_ready, 2'b01);
        exp_q.push_back(32'd16);
        cyc();
        ch_ray_id = {32'h0, 32'd17};
        #1;
        chk("bp_full_again", ch_ready, 0);
        ch_valid = 2'b00;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("bp_drain_valid", out_valid, 1);
            chk("bp_drain_id", out_ray_id, exp_q.pop_front());
            cyc();
        end
        #1;
        chk("bp_empty", out_valid, 0);
        chk("bp_results", result_count, 17);
        finish_run();

        // Finish with four entries held, then drain
        start_run();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ch_valid = 2'b01;
            ch_ray_id = {32'h0, 32'(i + 32'h40)};
            cyc();
        end
        ch_valid = 2'b00;
        ch_finish = 2'b11;
        cyc();
        ch_finish = 2'b00;
        #1;
        chk("dr_busy", busy, 1);
        chk("dr_state", dbg_state, 2);
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("dr_busy_empty", busy, 1);
        chk("dr_empty", out_valid, 0);
        chk("dr_not_done", done, 0);
        cyc();
        chk("dr_done", done, 1);
        chk("dr_cycles", cycle_count, 10);
        chk("dr_results", result_count, 4);
        repeat (3) cyc();
        chk("dr_cycles_frozen", cycle_count, 10);

        // Watchdog with no valids
        start_run();
        repeat (99) cyc();
        chk("wd_not_yet", done, 0);
        chk("wd_busy", busy, 1);
        cyc();
        chk("wd_done", done, 1);
        chk("wd_timeout", timeout, 1);
        chk("wd_cycles", cycle_count, 100);

        // Reset in the middle of a run
        start_run();
        chk("mr_timeout_cleared", timeout, 0);
        out_ready = 1'b0;
        ch_valid = 2'b01;
        ch_ray_id = {32'h0, 32'h5};
        cyc();
        cyc();
        ch_valid = 2'b00;
        #1;
        chk("mr_out_valid_before", out_valid, 1);
        chk("mr_results_before", result_count, 2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_results", result_count, 0);
        chk("mr_cycles", cycle_count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_state", dbg_state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtp_result_collector.md
Name: rtp_result_collector

Overview:
Parametrised, synthesizable result collector and performance monitor for the ray-traversal (RTP) core. It gathers per-ray hit results (ray id, hitT) from NUM_CH traversal channels using a round-robin arbiter and a FIFO. It also measures run length (cycles), result and miss counts, and a no-progress watchdog. It replaces ad-hoc bench-side cycle counting and finish polling with an on-chip block that supports multiple channels, backpressure and timeout detection.

Parameters:
NUM_CH, 2, number of traversal channels (>=1)
ID_W, 32, ray id width
T_W, 32, hitT width
FIFO_DEPTH, 16, result FIFO entries (power of 2, >=2)
CNT_W, 64, cycle counter width
TIMEOUT, 1000000, cycles without an accepted result before abort; 0 disables the watchdog
MISS_VALUE, 32'h7F7FFFFF, hitT value that encodes a miss (compared over T_W bits)

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse that starts or restarts a run
ch_valid  input  NUM_CH  per-channel result valid
ch_ready  output  NUM_CH  per-channel result accepted
ch_ray_id  input  NUM_CH*ID_W  packed ray ids; channel i occupies bits [i*ID_W +: ID_W]
ch_hitT  input  NUM_CH*T_W  packed hitT values, packed the same way
ch_finish  input  NUM_CH  per-channel finished flag
out_valid  output  1  head of the result FIFO is valid
out_ready  input  1  consumer pops the FIFO head
out_ray_id  output  ID_W  ray id at the FIFO head
out_hitT  output  T_W  hitT at the FIFO head
out_ch  output  max(1,clog2(NUM_CH))  source channel of the FIFO head
busy  output  1  state is RUN or DRAIN
done  output  1  state is DONE
timeout  output  1  the last run ended on the watchdog
cycle_count  output  CNT_W  number of RUN and DRAIN cycles in the current or last run
result_count  output  32  results accepted in the run
miss_count  output  32  accepted results with hitT == MISS_VALUE

Behaviour:
- Reset is decided: reset, synchronous, active-high; clock is clock. Reset forces state IDLE, empties the FIFO, sets the round-robin pointer to 0 and clears all counters, sticky flags and outputs. The same applies when reset is asserted mid-run; in-flight FIFO data is discarded.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: all sticky finish flags set -> DRAIN. Watchdog expiry -> DONE with timeout=1.
  - DRAIN: FIFO empty and no ch_valid asserted -> DONE.
  - DONE: start -> RUN.
- Entering RUN (from IDLE or DONE) clears in one cycle: cycle_count, result_count, miss_count, timeout, sticky finish flags, the watchdog counter and the FIFO.
- cycle_count increments every cycle in RUN and DRAIN, including the first RUN cycle. It is frozen in IDLE and DONE and saturates at all-ones.
- Sticky finish: flag i is set when ch_finish[i]=1 while in RUN.
- Arbitration:
  - Applies in RUN and DRAIN only; in IDLE and DONE, ch_ready=0.
  - At most one channel is granted per cycle: the first valid channel at or after the pointer, searching circularly.
  - ch_ready[g]=1 only for the granted channel g, and only if the FIFO is not full. Full means no grant, even if a pop occurs in the same cycle.
  - On acceptance, the pointer moves to g+1 mod NUM_CH.
  - ch_ready depends combinationally on ch_valid, the pointer and the FIFO state.
- Acceptance side effects:
  - The result is pushed with its channel index.
  - result_count increments (saturating).
  - miss_count increments when hitT==MISS_VALUE.
  - The watchdog counter clears.
- FIFO:
  - First-word-fall-through. out_valid = not empty.
  - An accepted result is visible on out_* in the cycle after acceptance.
  - A pop occurs when out_valid and out_ready are both 1.
  - A simultaneous push and pop when non-empty keeps occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_* hold stable while out_valid=1 and out_ready=0.
  - Popping continues in DONE until the FIFO is empty.
- Watchdog:
  - Active only in RUN, and only when TIMEOUT!=0.
  - Counts cycles with no acceptance.
  - When the count reaches TIMEOUT-1 with no acceptance, the next state is DONE and timeout=1.
- Simultaneous events:
  - A start pulse in RUN or DRAIN is ignored.
  - An acceptance in the same cycle as the final finish is still counted.
  - Finish flags set in DRAIN have no effect.

Test Plan:
- Reset check: hold reset 3 cycles -> ch_ready=0, out_valid=0, busy=0, done=0, timeout=0, and all counts 0 the cycle after release.
- Single stream (NUM_CH=2, out_ready=1): start, then ch0 sends ids 0,1,2 with hitT=0x3F800000, 0x7F7FFFFF, 0x40000000 -> out_* presents ids 0,1,2 in order with out_ch=0, each one cycle after acceptance; result_count=3, miss_count=1.
- Round-robin: both channels valid continuously for 6 cycles -> grant order ch0,ch1,ch0,ch1,ch0,ch1; out_ch follows the same order.
- Backpressure (FIFO_DEPTH=16): out_ready=0 with ch0 valid -> 16 accepts, then ch_ready[0]=0. One pop -> exactly one further accept. Data order is preserved across wrap-around.
- Finish/drain: FIFO holds 4 entries, both ch_finish assert -> busy=1 during DRAIN until 4 pops; done=1 the cycle after the FIFO empties; cycle_count equals the number of RUN+DRAIN cycles and then stays frozen.
- Watchdog and reset mid-run: TIMEOUT=100 with no valids -> done=1 and timeout=1 exactly 100 cycles after entering RUN. In a separate run, assert reset mid-RUN -> FIFO empty, counts 0, state IDLE.
